// File: rtl/match_engine.sv
// Judging engine for the card array: snapshots the selection, scans for the two
// lowest selected live cards, compares their faces and pulses ms or mf once.
module match_engine #(
  parameter int unsigned N_CARDS = 36,
  parameter int unsigned FACE_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CARDS-1:0]          sel_bus,
  input  logic [N_CARDS-1:0]          hidden_bus,
  input  logic [N_CARDS*FACE_W-1:0]   face_bus,
  output logic                        ms,
  output logic                        mf,
  output logic                        busy,
  output logic [4:0]                  pair_count,
  output logic                        done
);

  localparam int unsigned IDX_W     = $clog2(N_CARDS);
  localparam int unsigned PC_W      = 5;
  localparam int unsigned MAX_PAIRS = N_CARDS / 2;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    COMPARE,
    RESULT,
    WAIT_CLR
  } state_t;

  state_t             state;
  logic [N_CARDS-1:0] snap;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   a_idx;
  logic [IDX_W-1:0]   b_idx;
  logic [1:0]         found;
  logic               eq;

  logic [N_CARDS-1:0] sel_eff;
  logic               two_plus;
  logic [FACE_W-1:0]  face_a;
  logic [FACE_W-1:0]  face_b;
  logic               face_eq;

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    sel_eff  = sel_bus & ~hidden_bus;
    two_plus = |(sel_eff & (sel_eff - N_CARDS'(1)));
    face_a   = face_bus[int'(a_idx)*FACE_W +: FACE_W];
    face_b   = face_bus[int'(b_idx)*FACE_W +: FACE_W];
    face_eq  = (face_a == face_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      snap       <= '0;
      idx        <= '0;
      a_idx      <= '0;
      b_idx      <= '0;
      found      <= '0;
      eq         <= 1'b0;
      ms         <= 1'b0;
      mf         <= 1'b0;
      busy       <= 1'b0;
      pair_count <= '0;
      done       <= 1'b0;
    end else begin
      done <= &hidden_bus;
      case (state)
        IDLE: begin
          if (two_plus) begin
            snap  <= sel_eff;
            idx   <= '0;
            found <= '0;
            a_idx <= '0;
            b_idx <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          // Only the lowest two set bits are recorded.
          if (snap[idx]) begin
            if (found == 2'd0) begin
              a_idx <= idx;
              found <= 2'd1;
            end else if (found == 2'd1) begin
              b_idx <= idx;
              found <= 2'd2;
            end
          end
          if (idx == IDX_W'(N_CARDS - 1)) begin
            state <= COMPARE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        COMPARE: begin
          eq    <= face_eq;
          ms    <= face_eq;
          mf    <= ~face_eq;
          state <= RESULT;
        end
        RESULT: begin
          ms <= 1'b0;
          mf <= 1'b0;
          if (eq && (pair_count < PC_W'(MAX_PAIRS))) begin
            pair_count <= pair_count + PC_W'(1);
          end
          state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (sel_eff == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_engine.sv
// Directed bench for match_engine: table of judgement vectors plus hand-written
// sequences for snapshot isolation, saturation, done and reset abort.
module tb_match_engine;

  logic          clk;
  logic          rst;
  logic [35:0]   sel_bus;
  logic [35:0]   hidden_bus;
  logic [107:0]  face_bus;
  logic          ms;
  logic          mf;
  logic          busy;
  logic [4:0]    pair_count;
  logic          done;

  int passed;
  int total;
  int exp_pc;

  match_engine #(.N_CARDS(36), .FACE_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_bus    (sel_bus),
    .hidden_bus (hidden_bus),
    .face_bus   (face_bus),
    .ms         (ms),
    .mf         (mf),
    .busy       (busy),
    .pair_count (pair_count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [35:0] sel;
    logic [35:0] hid;
    int          ia;
    int          fa;
    int          ib;
    int          fb;
    bit          scan;
    bit          match;
    bit          hide;
    int          hold;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [35:0] bit2(input int a, input int b);
    logic [35:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [107:0] mkface(input int ia, input int fa, input int ib, input int fb);
    logic [107:0] f;
    for (int i = 0; i < 36; i++) f[3*i +: 3] = 3'(i % 7);
    if (ia >= 0) f[3*ia +: 3] = 3'(fa);
    if (ib >= 0) f[3*ib +: 3] = 3'(fb);
    return f;
  endfunction

  // Starts a judgement at the current negedge (cycle T) and checks the timeline.
  task automatic judge(input logic [35:0] s, input logic [35:0] h, input logic [107:0] f,
                       input bit scan, input bit match, input bit hide, input int hold,
                       input int mid_n, input logic [35:0] mid_sel, input string tag);
    sel_bus = s; hidden_bus = h; face_bus = f;
    if (!scan) begin
      int seen;
      seen = 0;
      for (int n = 1; n <= 6; n++) begin
        @(negedge clk);
        if (busy || ms || mf) seen = 1;
      end
      chk({tag, "_noscan"}, 32'(seen), 0);
      chk({tag, "_pc"}, 32'(pair_count), 32'(exp_pc));
      sel_bus = '0;
      @(negedge clk);
      return;
    end
    if (match && exp_pc < 18) exp_pc++;
    for (int n = 1; n <= 39; n++) begin
      @(negedge clk);
      if (n == mid_n) sel_bus = mid_sel;
      if (n == 1)  chk({tag, "_busy_T1"}, 32'(busy), 1);
      if (n == 37) begin
        chk({tag, "_ms_T37"}, 32'(ms), 0);
        chk({tag, "_mf_T37"}, 32'(mf), 0);
      end
      if (n == 38) begin
        chk({tag, "_ms_T38"}, 32'(ms), 32'(match));
        chk({tag, "_mf_T38"}, 32'(mf), 32'(!match));
      end
      if (n == 39) begin
        chk({tag, "_ms_T39"}, 32'(ms), 0);
        chk({tag, "_mf_T39"}, 32'(mf), 0);
        chk({tag, "_pc_T39"}, 32'(pair_count), 32'(exp_pc));
      end
    end
    repeat (hold) @(negedge clk);
    chk({tag, "_busy_hold"}, 32'(busy), 1);
    sel_bus = '0;
    if (hide) hidden_bus = h | s;
    @(negedge clk);
    chk({tag, "_busy_exit"}, 32'(busy), 0);
    @(negedge clk);
  endtask

  initial begin
    passed = 0; total = 0; exp_pc = 0;
    rst = 1'b1;
    sel_bus = 36'($urandom()) | 36'h300000000;
    hidden_bus = 36'($urandom());
    face_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ms", 32'(ms), 0);
    chk("rst_mf", 32'(mf), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pc", 32'(pair_count), 0);
    sel_bus = '0; hidden_bus = '0; rst = 1'b0;
    @(negedge clk);

    vecs[0] = '{bit2(3, 17), '0, 3, 5, 17, 5, 1, 1, 1, 0};
    vecs[1] = '{bit2(0, 35), bit2(3, 17), 0, 1, 35, 2, 1, 0, 0, 4};
    vecs[2] = '{bit2(10, -1), bit2(3, 17), 10, 1, -1, 0, 0, 0, 0, 0};
    vecs[3] = '{bit2(4, 5), bit2(5, 3) | bit2(17, -1), 4, 2, 5, 2, 0, 0, 0, 0};
    vecs[4] = '{bit2(3, 17) | bit2(8, 9), bit2(3, 17), 8, 6, 9, 6, 1, 1, 1, 0};
    for (int v = 0; v < 5; v++)
      judge(vecs[v].sel, vecs[v].hid, mkface(vecs[v].ia, vecs[v].fa, vecs[v].ib, vecs[v].fb),
            vecs[v].scan, vecs[v].match, vecs[v].hide, vecs[v].hold, 0, '0, $sformatf("vec%0d", v));

    // Snapshot isolation: live lowest pair would be (1,2) with differing faces.
    begin
      logic [107:0] f;
      f = mkface(2, 4, 7, 4);
      f[3*30 +: 3] = 3'd1;
      f[3*1 +: 3]  = 3'd6;
      judge(bit2(2, 7) | bit2(30, -1), '0, f, 1, 1, 0, 0, 5, bit2(2, 7) | bit2(1, -1), "midscan");
    end

    for (int k = 0; k < 19; k++)
      judge(bit2(20, 21), '0, mkface(20, 3, 21, 3), 1, 1, 0, 0, 0, '0, $sformatf("sat%0d", k));
    chk("sat_final", 32'(pair_count), 18);

    hidden_bus = '1;
    chk("done_before", 32'(done), 0);
    @(negedge clk);
    chk("done_after", 32'(done), 1);
    hidden_bus = '0;
    @(negedge clk);

    // Reset during SCAN aborts the judgement with no pulse.
    begin
      int pulses;
      pulses = 0;
      sel_bus = bit2(20, 21); face_bus = mkface(20, 3, 21, 3);
      for (int n = 1; n <= 42; n++) begin
        @(negedge clk);
        if (n == 20) begin rst = 1'b1; sel_bus = '0; end
        if (n == 21) begin
          rst = 1'b0;
          chk("abort_busy", 32'(busy), 0);
          chk("abort_pc", 32'(pair_count), 0);
        end
        if (n > 20 && (ms || mf)) pulses++;
      end
      chk("abort_pulses", 32'(pulses), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
